sisc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the SISC datapath. It sits upstream of the control FSM: it holds the PC and the instruction register (IR), and presents opcode/mm fields to the FSM. It executes the FSM's pc_rst/pc_write/pc_sel/br_sel/ir_load commands. Instruction memory is reached through a req/rdy handshake with variable latency, and the unit stalls the FSM while a fetch is outstanding.

---
 rtl/sisc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_sisc_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - SISC program counter, instruction register and fetch handshake FSM.
// Optional macro FETCH_TIMEOUT_EN adds a fetch wait-limit that loads a NOOP and sets sticky fetch_err.
module sisc_fetch_unit #(
  parameter int PC_W           = 16,
  parameter int INSTR_W        = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [PC_W-1:0]    pc_out,
  output logic               stall,
  output logic               fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic [PC_W-1:0] imm_sx;
  logic [PC_W-1:0] pc_next;
  logic            timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign imm    = ir[15:0];
  assign imm_sx = PC_W'($signed(imm));

  // All PC arithmetic wraps naturally at PC_W bits.
  always_comb begin
    pc_next = pc_out + PC_W'(1);
    if (pc_sel) begin
      pc_next = br_sel ? PC_W'(imm) : pc_out + imm_sx;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counter is zero in IDLE, so it starts from zero on every REQ entry.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wait_cnt <= '0;
    end else if (pc_rst || state == IDLE) begin
      wait_cnt <= '0;
    end else if (!imem_rdy) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      pc_out    <= '0;
      ir        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      stall     <= 1'b0;
      fetch_err <= 1'b0;
    end else if (pc_rst) begin
      state     <= IDLE;
      pc_out    <= '0;
      ir        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      stall     <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      if (pc_write && !stall) begin
        pc_out <= pc_next;
      end
      case (state)
        IDLE: begin
          // Address captures the pre-update PC so fetch and PC advance can share a cycle.
          if (ir_load) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_out;
            stall     <= 1'b1;
          end
        end
        REQ, WAIT: begin
          imem_req <= 1'b0;
          if (imem_rdy) begin
            ir    <= imem_data;
            stall <= 1'b0;
            state <= IDLE;
          end else if (timeout) begin
            ir        <= '0;
            fetch_err <= 1'b1;
            stall     <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb/tb_sisc_fetch_unit.sv - directed self-checking bench for sisc_fetch_unit.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        ir_load;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        stall;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  sisc_fetch_unit dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .pc_rst    (pc_rst),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .ir_load   (ir_load),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdy  (imem_rdy),
    .imem_data (imem_data),
    .ir        (ir),
    .opcode    (opcode),
    .mm        (mm),
    .imm       (imm),
    .pc_out    (pc_out),
    .stall     (stall),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch with `lat` non-ready cycles before the ready cycle (0 = ready in REQ).
  task automatic do_fetch(input logic [31:0] data, input int lat);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    repeat (lat) tick();
    imem_rdy  = 1'b1;
    imem_data = data;
    tick();
    imem_rdy  = 1'b0;
  endtask

  task automatic pc_op(input logic sel, input logic br);
    pc_write = 1'b1;
    pc_sel   = sel;
    br_sel   = br;
    tick();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
  endtask

  initial begin
    rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    ir_load = 1'b0; imem_rdy = 1'b0; imem_data = 32'h0;
    tick();
    tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", imem_req, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_stall", stall, 32'h0);
    chk("rst_err", fetch_err, 32'h0);
    rst_f = 1'b1;
    tick();

    // Fetch with simultaneous PC increment, ready in REQ cycle
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    ir_load = 1'b0; pc_write = 1'b0;
    chk("f1_req", imem_req, 32'h1);
    chk("f1_addr", imem_addr, 32'h0);
    chk("f1_stall", stall, 32'h1);
    chk("f1_pc", pc_out, 32'h1);
    imem_rdy = 1'b1; imem_data = 32'h8123_0005;
    tick();
    imem_rdy = 1'b0;
    chk("f1_ir", ir, 32'h8123_0005);
    chk("f1_opcode", opcode, 32'h8);
    chk("f1_mm", mm, 32'h1);
    chk("f1_imm", imm, 32'h0005);
    chk("f1_stall_clr", stall, 32'h0);
    chk("f1_req_clr", imem_req, 32'h0);

    // Branches
    do_fetch(32'h0000_0010, 0);
    pc_op(1'b1, 1'b1);
    chk("br_abs_10", pc_out, 32'h0010);
    do_fetch(32'h0000_FFFE, 0);
    pc_op(1'b1, 1'b0);
    chk("br_rel_m2", pc_out, 32'h000E);
    do_fetch(32'h0000_0040, 1);
    pc_op(1'b1, 1'b1);
    chk("br_abs_40", pc_out, 32'h0040);

    // Wrap boundaries
    do_fetch(32'h0000_FFFF, 0);
    pc_op(1'b1, 1'b1);
    chk("pc_ffff", pc_out, 32'hFFFF);
    pc_op(1'b0, 1'b0);
    chk("inc_wrap", pc_out, 32'h0000);
    pc_op(1'b1, 1'b0);
    chk("rel_wrap", pc_out, 32'hFFFF);

    // 4-cycle memory; pc_write/ir_load pulses during stall are ignored
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("lat_req", imem_req, 32'h1);
    chk("lat_addr", imem_addr, 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      pc_write = 1'b1; ir_load = 1'b1;
      tick();
      pc_write = 1'b0; ir_load = 1'b0;
      chk("lat_stall", stall, 32'h1);
      chk("lat_req_low", imem_req, 32'h0);
      chk("lat_pc_hold", pc_out, 32'hFFFF);
      chk("lat_ir_hold", ir, 32'h0000_FFFF);
    end
    imem_rdy = 1'b1; imem_data = 32'hA5C3_1234; ir_load = 1'b1; pc_write = 1'b1;
    tick();
    imem_rdy = 1'b0; ir_load = 1'b0; pc_write = 1'b0;
    chk("lat_ir", ir, 32'hA5C3_1234);
    chk("lat_stall_clr", stall, 32'h0);
    chk("lat_pc_final", pc_out, 32'hFFFF);
    imem_data = 32'h0BAD_0BAD;
    tick();
    chk("lat_noqueue_stall", stall, 32'h0);
    chk("lat_noqueue_req", imem_req, 32'h0);
    chk("lat_ir_once", ir, 32'hA5C3_1234);

    // pc_rst during WAIT aborts the fetch
    pc_op(1'b1, 1'b1);
    chk("pcrst_pre_pc", pc_out, 32'h1234);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    tick();
    chk("pcrst_wait_stall", stall, 32'h1);
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    chk("pcrst_pc", pc_out, 32'h0);
    chk("pcrst_ir", ir, 32'h0);
    chk("pcrst_stall", stall, 32'h0);
    chk("pcrst_addr", imem_addr, 32'h0);
    imem_rdy = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    imem_rdy = 1'b0;
    chk("late_rdy_ir", ir, 32'h0);
    chk("late_rdy_stall", stall, 32'h0);

    // Unanswered fetch
    do_fetch(32'h1111_2222, 2);
    chk("pre_to_ir", ir, 32'h1111_2222);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (14) tick();
    chk("to_stall_14", stall, 32'h1);
    chk("to_err_14", fetch_err, 32'h0);
    tick();
    chk("to_stall_15", stall, 32'h0);
    chk("to_err_15", fetch_err, 32'h1);
    chk("to_ir_noop", ir, 32'h0);
    do_fetch(32'h3333_4444, 1);
    chk("to_good_ir", ir, 32'h3333_4444);
    chk("to_err_sticky", fetch_err, 32'h1);
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    chk("to_err_clr", fetch_err, 32'h0);
`else
    repeat (20) tick();
    chk("nto_stall", stall, 32'h1);
    chk("nto_err", fetch_err, 32'h0);
    chk("nto_ir", ir, 32'h1111_2222);
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    chk("nto_abort_stall", stall, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
